tag_free_list: RTL and testbench
================================

Name: tag_free_list

Overview:
- Physical register tag allocator, sitting on the opposite side of the rename allocate/commit-free handshake.
- Rename requests up to NUM_ISSUE fresh tags per cycle; this block supplies them.
- Commit returns freed tags (previous mappings, or dead destinations) to this block.
- Implemented as a circular free FIFO with three pointers: speculative read, committed read and write. Mispredict recovery rewinds the speculative read pointer at flush.

Parameters:
- NUM_TAGS, 64, physical tag count; power of two; equals the FIFO depth.
- NUM_ISSUE, `DEC_WIDTH, allocation ports.
- NUM_COMMIT, 4, commit/free ports.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- IN_mispr  in  1  branch mispredict taken this cycle
- IN_mispredFlush  in  1  ROB drained after mispredict; rewind allocations
- IN_issueValid  in  NUM_ISSUE x 1  slot i consumes a tag this cycle
- OUT_issueTags  out  NUM_ISSUE x $bits(RFTag)  tag offered to slot i
- OUT_issueTagsValid  out  NUM_ISSUE x 1  slot i may allocate
- IN_commitValid  in  NUM_COMMIT x 1  committed uop
- IN_commitNewest  in  NUM_COMMIT x 1  uop is youngest writer of its rd in this commit group
- IN_RAT_commitPrevTags  in  NUM_COMMIT x $bits(Tag)  previous committed mapping of rd
- IN_commitTagDst  in  NUM_COMMIT x $bits(Tag)  committed destination tag
- OUT_freeCount  out  $clog2(NUM_TAGS)+1  speculatively free tags, registered

Behaviour:
- State:
  - fifo[NUM_TAGS] of RFTag.
  - specRd, comRd, wr: $clog2(NUM_TAGS)+1 bits each; the top bit is wrap parity; index = low bits.
- Free counts: specFree = wr - specRd; comFree = wr - comRd (modular subtraction).
- Reset:
  - fifo[k] = k; specRd = comRd = 0; wr = NUM_TAGS.
  - All tags free; OUT_freeCount = NUM_TAGS.
  - Reset overrides any concurrent issue, commit or flush.
- Offer (combinational):
  - p_i = popcount(IN_issueValid[i-1:0]).
  - OUT_issueTags[i] = fifo[specRd + p_i].
  - OUT_issueTagsValid[i] = (specFree > i) && !IN_mispredFlush. It must not depend on IN_issueValid, which breaks the stall loop.
- Allocate: specRd += popcount(IN_issueValid), one-cycle update. Issuing with specFree too small is illegal (assertion).
- A tag is "real" iff Tag MSB == 0.
- Commit, per valid slot j, in slot order:
  - If IN_commitTagDst[j] is real: comRd += 1.
  - If IN_commitNewest[j] and IN_RAT_commitPrevTags[j] is real: push the prev tag.
  - If !IN_commitNewest[j] and IN_commitTagDst[j] is real: push tagDst (dead immediately: overwritten within the group, or rd = x0).
  - Pushes write fifo[wr + q] with q = prefix count of pushes; then wr += total pushes.
  - Frees become visible to the offer logic the next cycle.
- Mispredict:
  - IN_mispr alone changes no state; rename stalls itself.
  - IN_mispredFlush sets specRd = comRd (after that cycle's commit increments), discarding all speculative allocations.
  - Same-cycle issue is ignored during a flush.
- Simultaneous events:
  - Issue and commit in one cycle both apply.
  - Pointer wrap is handled by modular arithmetic.
  - specFree == 0: no offers; commit still frees.
  - Tags freed this cycle are never offered in the same cycle.
- Invariants (assertions): comFree ≤ NUM_TAGS; specFree ≤ comFree; wr - comRd ≤ NUM_TAGS after push.
- OUT_freeCount registers the next value of specFree.

Optional Feature:
- TAG_FREE_LIST_CHECK_EN enables a NUM_TAGS-bit freeMap:
  - Reset sets all bits.
  - Allocation clears bit.
  - Push sets bit.
  - Flush restores bits of rewound entries, by recomputing from the FIFO window [comRd, wr).
  - Pushing an already-free tag, or offering a non-free tag, fires $error and sets a sticky debug flag OUT_dblFree (extra port, exists only under the macro).
- Without the macro: no map, no port, no checks; logic identical otherwise.

Decomposition:
- Shared package: RFTag, Tag, TAG_ZERO, and a free-list pointer typedef FLPtr = logic[$clog2(NUM_TAGS):0].
- Sub-module tag_prefix_count: parametric prefix popcount, reused for the issue and push index computation.

Test Plan:
- Reset then 4 issue slots valid for 16 cycles -> tags 0..63 delivered in order; cycle 16: all OUT_issueTagsValid = 0, OUT_freeCount = 0.
- IN_issueValid = 1010 with specRd = 5 -> slot1 gets tag 5, slot3 gets tag 6; specRd becomes 7.
- Commit slot0 newest with prevTag 9 and tagDst 5; slot1 rd = x0 with tagDst 6 -> fifo[wr] = 9, fifo[wr+1] = 6; comRd += 2; freeCount +2 next cycle.
- Allocate 10 tags, commit 3, then IN_mispredFlush -> specRd = comRd; freeCount = 61; next offer is the 4th allocated tag.
- Pointer wrap: run 200 cycles of random issue and matched commits -> no duplicate tag live at any time (scoreboard); counts never exceed 64.
- TAG_FREE_LIST_CHECK_EN: push tag 3 while it is already free -> OUT_dblFree = 1 next cycle and stays set.

Source files
------------

// File: rtl/tag_free_list_pkg.sv
// Shared types for the physical register tag free list: tag formats and the
// wrap-parity pointer type used by the circular free FIFO.
`ifndef DEC_WIDTH
`define DEC_WIDTH 4
`endif

package tag_free_list_pkg;

  localparam int FL_NUM_TAGS = 64;
  localparam int FL_TAG_BITS = $clog2(FL_NUM_TAGS);

  typedef logic [FL_TAG_BITS-1:0]       RFTag;
  typedef logic [FL_TAG_BITS:0]         Tag;
  typedef logic [$clog2(FL_NUM_TAGS):0] FLPtr;

  // MSB set marks a non-physical mapping such as x0.
  localparam Tag TAG_ZERO = {1'b1, {FL_TAG_BITS{1'b0}}};

  function automatic logic tag_is_real(input Tag t);
    return !t[FL_TAG_BITS];
  endfunction

endpackage

// File: rtl/tag_prefix_count.sv
// Exclusive prefix popcount: prefix[i] counts set bits below i, total counts all.
module tag_prefix_count #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         in_vec,
  output logic [N-1:0][CW-1:0] prefix,
  output logic [CW-1:0]        total
);

  logic [CW-1:0] acc;

  always_comb begin
    // NOTE: every output and temporary gets a value before any branch or loop,
    // so no path leaves a signal holding its old value and no latch is inferred.
    acc    = '0;
    prefix = '0;
    for (int i = 0; i < N; i++) begin
      prefix[i] = acc;
      acc       = acc + CW'(in_vec[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/tag_free_list.sv
// Circular free-tag FIFO with speculative read, committed read and write pointers.
// Optional TAG_FREE_LIST_CHECK_EN adds a free map and the sticky OUT_dblFree flag.
module tag_free_list
  import tag_free_list_pkg::*;
#(
  parameter int NUM_TAGS   = FL_NUM_TAGS,
  parameter int NUM_ISSUE  = `DEC_WIDTH,
  parameter int NUM_COMMIT = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 IN_mispr,
  input  logic                                 IN_mispredFlush,
  input  logic [NUM_ISSUE-1:0]                 IN_issueValid,
  output logic [NUM_ISSUE-1:0][$bits(RFTag)-1:0] OUT_issueTags,
  output logic [NUM_ISSUE-1:0]                 OUT_issueTagsValid,
  input  logic [NUM_COMMIT-1:0]                IN_commitValid,
  input  logic [NUM_COMMIT-1:0]                IN_commitNewest,
  input  logic [NUM_COMMIT-1:0][$bits(Tag)-1:0] IN_RAT_commitPrevTags,
  input  logic [NUM_COMMIT-1:0][$bits(Tag)-1:0] IN_commitTagDst,
`ifdef TAG_FREE_LIST_CHECK_EN
  output logic                                 OUT_dblFree,
`endif
  output logic [$bits(FLPtr)-1:0]              OUT_freeCount
);

  localparam int TW  = $bits(RFTag);
  localparam int ICW = $clog2(NUM_ISSUE + 1);
  localparam int PCW = $clog2(NUM_COMMIT + 1);

  FLPtr spec_rd_q, spec_rd_d, com_rd_q, com_rd_d, wr_q, wr_d;
  FLPtr free_count_q, free_count_d;
  RFTag fifo_q [NUM_TAGS];
  RFTag fifo_d [NUM_TAGS];

  FLPtr spec_free, com_free, com_free_next, com_inc;

  logic [NUM_ISSUE-1:0][ICW-1:0]  issue_prefix;
  logic [ICW-1:0]                 issue_total;
  logic [NUM_COMMIT-1:0]          push_vld;
  logic [NUM_COMMIT-1:0][TW-1:0]  push_tag;
  logic [NUM_COMMIT-1:0][PCW-1:0] push_prefix;
  logic [PCW-1:0]                 push_total;

  // Rename stalls itself on a mispredict; only the flush affects this block.
  logic unused_mispr;
  assign unused_mispr = IN_mispr;

  tag_prefix_count #(.N(NUM_ISSUE), .CW(ICW)) u_issue_cnt (
    .in_vec (IN_issueValid),
    .prefix (issue_prefix),
    .total  (issue_total)
  );

  tag_prefix_count #(.N(NUM_COMMIT), .CW(PCW)) u_push_cnt (
    .in_vec (push_vld),
    .prefix (push_prefix),
    .total  (push_total)
  );

  assign spec_free     = wr_q - spec_rd_q;
  assign com_free      = wr_q - com_rd_q;
  assign com_free_next = wr_d - com_rd_d;
  assign OUT_freeCount = free_count_q;

  // Offers are independent of IN_issueValid so rename can stall on them.
  always_comb begin
    OUT_issueTags      = '0;
    OUT_issueTagsValid = '0;
    for (int i = 0; i < NUM_ISSUE; i++) begin
      OUT_issueTags[i]      = fifo_q[spec_rd_q[TW-1:0] + RFTag'(issue_prefix[i])];
      OUT_issueTagsValid[i] = (spec_free > FLPtr'(i)) && !IN_mispredFlush;
    end
  end

  always_comb begin
    push_vld = '0;
    push_tag = '0;
    com_inc  = '0;
    for (int j = 0; j < NUM_COMMIT; j++) begin
      push_tag[j] = IN_commitNewest[j] ? IN_RAT_commitPrevTags[j][TW-1:0]
                                       : IN_commitTagDst[j][TW-1:0];
      if (IN_commitValid[j]) begin
        if (tag_is_real(IN_commitTagDst[j])) com_inc = com_inc + FLPtr'(1);
        push_vld[j] = IN_commitNewest[j] ? tag_is_real(IN_RAT_commitPrevTags[j])
                                         : tag_is_real(IN_commitTagDst[j]);
      end
    end
  end

  always_comb begin
    fifo_d = fifo_q;
    for (int j = 0; j < NUM_COMMIT; j++) begin
      if (push_vld[j]) fifo_d[wr_q[TW-1:0] + RFTag'(push_prefix[j])] = push_tag[j];
    end
    com_rd_d     = com_rd_q + com_inc;
    wr_d         = wr_q + FLPtr'(push_total);
    spec_rd_d    = IN_mispredFlush ? com_rd_d : spec_rd_q + FLPtr'(issue_total);
    free_count_d = wr_d - spec_rd_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the fifo contents are reset, not only the pointers, because at
      // reset the stored values themselves are the initial free tags.
      for (int k = 0; k < NUM_TAGS; k++) fifo_q[k] <= RFTag'(k);
      spec_rd_q    <= '0;
      com_rd_q     <= '0;
      wr_q         <= FLPtr'(NUM_TAGS);
      free_count_q <= FLPtr'(NUM_TAGS);
    end else begin
      // NOTE: non-blocking assignments make every flop load from the values
      // present before the edge, independent of statement order.
      fifo_q       <= fifo_d;
      spec_rd_q    <= spec_rd_d;
      com_rd_q     <= com_rd_d;
      wr_q         <= wr_d;
      free_count_q <= free_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (IN_mispredFlush || FLPtr'(issue_total) <= spec_free)
        else $error("tag_free_list: issue exceeds free tags");
      assert (com_free <= FLPtr'(NUM_TAGS))
        else $error("tag_free_list: committed free count overflow");
      assert (spec_free <= com_free)
        else $error("tag_free_list: speculative free exceeds committed free");
      assert (com_free_next <= FLPtr'(NUM_TAGS))
        else $error("tag_free_list: push overflows the fifo");
    end
  end

`ifdef TAG_FREE_LIST_CHECK_EN
  logic [NUM_TAGS-1:0] free_map_q, free_map_d;
  logic                dbl_free_q, dbl_free_d, dbl_evt;
  RFTag                win_off;

  always_comb begin
    free_map_d = free_map_q;
    dbl_evt    = 1'b0;
    win_off    = '0;
    for (int i = 0; i < NUM_ISSUE; i++) begin
      if (OUT_issueTagsValid[i] && !free_map_q[OUT_issueTags[i]]) dbl_evt = 1'b1;
      if (IN_issueValid[i] && !IN_mispredFlush) free_map_d[OUT_issueTags[i]] = 1'b0;
    end
    for (int j = 0; j < NUM_COMMIT; j++) begin
      if (push_vld[j]) begin
        if (free_map_q[push_tag[j]]) dbl_evt = 1'b1;
        free_map_d[push_tag[j]] = 1'b1;
      end
    end
    // A flush rebuilds the map from the committed window [comRd, wr).
    if (IN_mispredFlush) begin
      free_map_d = '0;
      for (int e = 0; e < NUM_TAGS; e++) begin
        win_off = RFTag'(e) - com_rd_d[TW-1:0];
        if ({1'b0, win_off} < com_free_next) free_map_d[fifo_d[e]] = 1'b1;
      end
    end
    dbl_free_d = dbl_free_q | dbl_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_map_q <= '1;
      dbl_free_q <= 1'b0;
    end else begin
      free_map_q <= free_map_d;
      dbl_free_q <= dbl_free_d;
      if (dbl_evt) $error("tag_free_list: double free or non-free tag offered");
    end
  end

  assign OUT_dblFree = dbl_free_q;
`endif

endmodule

// File: tb/tb_tag_free_list.sv
// Scoreboard bench for tag_free_list: directed stimulus queues expectations,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_tag_free_list;
  import tag_free_list_pkg::*;

  typedef struct { int cyc; int val; } exp_t;

  logic            clk;
  logic            rst;
  logic            mispr, flush;
  logic [3:0]      issue_valid;
  logic [3:0][5:0] issue_tags;
  logic [3:0]      issue_tags_valid;
  logic [3:0]      commit_valid, commit_newest;
  logic [3:0][6:0] commit_prev, commit_dst;
  logic [6:0]      free_count;
`ifdef TAG_FREE_LIST_CHECK_EN
  logic            dbl_free;
`endif

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   rand_mode = 0;
  bit   live [64];
  exp_t fc_q[$], vld_q[$], dbl_q[$];
  int   tag_q[$];
  int   rob[$];

  tag_free_list #(.NUM_TAGS(64), .NUM_ISSUE(4), .NUM_COMMIT(4)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .IN_mispr              (mispr),
    .IN_mispredFlush       (flush),
    .IN_issueValid         (issue_valid),
    .OUT_issueTags         (issue_tags),
    .OUT_issueTagsValid    (issue_tags_valid),
    .IN_commitValid        (commit_valid),
    .IN_commitNewest       (commit_newest),
    .IN_RAT_commitPrevTags (commit_prev),
    .IN_commitTagDst       (commit_dst),
`ifdef TAG_FREE_LIST_CHECK_EN
    .OUT_dblFree           (dbl_free),
`endif
    .OUT_freeCount         (free_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mispr = 0; flush = 0; issue_valid = '0;
    commit_valid = '0; commit_newest = '0;
    for (int j = 0; j < 4; j++) begin
      commit_prev[j] = TAG_ZERO;
      commit_dst[j]  = TAG_ZERO;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic exp_fc(input int c, input int v);  fc_q.push_back('{c, v});  endtask
  task automatic exp_vld(input int c, input int v); vld_q.push_back('{c, v}); endtask

  // Monitor: compares whatever expectations are due in the current cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    int   t;
    if (!rst) begin
      while (fc_q.size() > 0 && fc_q[0].cyc < cyc) begin
        e = fc_q.pop_front(); check("free_count_missed", 0, 1);
      end
      if (fc_q.size() > 0 && fc_q[0].cyc == cyc) begin
        e = fc_q.pop_front(); check("free_count", int'(free_count), e.val);
      end
      while (vld_q.size() > 0 && vld_q[0].cyc < cyc) begin
        e = vld_q.pop_front(); check("tags_valid_missed", 0, 1);
      end
      if (vld_q.size() > 0 && vld_q[0].cyc == cyc) begin
        e = vld_q.pop_front(); check("tags_valid", int'(issue_tags_valid), e.val);
      end
`ifdef TAG_FREE_LIST_CHECK_EN
      if (dbl_q.size() > 0 && dbl_q[0].cyc == cyc) begin
        e = dbl_q.pop_front(); check("dbl_free", int'(dbl_free), e.val);
      end
`endif
      if (rand_mode) check("free_count_max", int'(free_count <= 7'd64), 1);
      for (int i = 0; i < 4; i++) begin
        if (issue_tags_valid[i] && issue_valid[i]) begin
          t = int'(issue_tags[i]);
          if (rand_mode) begin
            check("dup_tag", int'(live[t]), 0);
            live[t] = 1;
            rob.push_back(t);
          end else if (tag_q.size() == 0) begin
            check("unexpected_issue", t, -1);
          end else begin
            check("issue_tag", t, tag_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int n, avail, lim, mask, free_model;
    rst = 1;
    clear_inputs();

    // Reset state, then drain all 64 tags four per cycle.
    do_reset();
    exp_fc(cyc, 64);
    exp_vld(cyc, 4'hF);
    for (int k = 0; k < 16; k++) begin
      issue_valid = 4'hF;
      if (k > 0) exp_vld(cyc, 4'hF);
      for (int s = 0; s < 4; s++) tag_q.push_back(4 * k + s);
      exp_fc(cyc + 1, 64 - 4 * (k + 1));
      step();
    end
    issue_valid = '0;
    exp_vld(cyc, 4'h0);
    step();

    // Sparse issue pattern 1010 with specRd = 5.
    do_reset();
    issue_valid = 4'hF;
    for (int s = 0; s < 4; s++) tag_q.push_back(s);
    step();
    issue_valid = 4'h1;
    tag_q.push_back(4);
    step();
    issue_valid = 4'b1010;
    exp_vld(cyc, 4'hF);
    tag_q.push_back(5);
    tag_q.push_back(6);
    exp_fc(cyc + 1, 57);
    step();

    // Commit: newest with prev 9, dead destination 6.
    clear_inputs();
    commit_valid  = 4'b0011;
    commit_newest = 4'b0001;
    commit_prev[0] = 7'd9; commit_dst[0] = 7'd5;
    commit_dst[1]  = 7'd6;
    exp_fc(cyc + 1, 59);
    step();
    clear_inputs();
    for (int k = 0; k < 14; k++) begin
      issue_valid = 4'hF;
      exp_vld(cyc, 4'hF);
      for (int s = 0; s < 4; s++) tag_q.push_back(7 + 4 * k + s);
      step();
    end
    // Wrap: last original tag, then the two pushed tags in slot order.
    issue_valid = 4'b0111;
    exp_vld(cyc, 4'b0111);
    tag_q.push_back(63); tag_q.push_back(9); tag_q.push_back(6);
    exp_fc(cyc + 1, 0);
    step();
    issue_valid = '0;
    exp_vld(cyc, 4'h0);
    step();

    // Allocate 10, mispredict, then commit 3 with flush in the same cycle.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      issue_valid = (k < 2) ? 4'hF : 4'b0011;
      for (int s = 0; s < ((k < 2) ? 4 : 2); s++) tag_q.push_back(4 * k + s);
      step();
    end
    issue_valid = '0;
    mispr = 1;
    exp_vld(cyc, 4'hF);
    exp_fc(cyc + 1, 54);
    step();
    issue_valid   = 4'hF;
    flush         = 1;
    commit_valid  = 4'b0111;
    commit_newest = 4'b0111;
    for (int j = 0; j < 3; j++) commit_dst[j] = 7'(j);
    exp_vld(cyc, 4'h0);
    exp_fc(cyc + 1, 61);
    step();
    clear_inputs();
    issue_valid = 4'h1;
    exp_vld(cyc, 4'hF);
    tag_q.push_back(3);
    exp_fc(cyc + 1, 60);
    step();
    clear_inputs();
    step();

    // Random issue with in-order dead-destination commits across several wraps.
    do_reset();
    for (int t = 0; t < 64; t++) live[t] = 0;
    rob.delete();
    rand_mode  = 1;
    free_model = 64;
    for (int k = 0; k < 200; k++) begin
      clear_inputs();
      n = $urandom_range(0, 4);
      if (n > rob.size()) n = rob.size();
      for (int j = 0; j < n; j++) begin
        commit_valid[j] = 1;
        commit_dst[j]   = 7'(rob[0]);
        live[rob[0]]    = 0;
        void'(rob.pop_front());
      end
      avail = free_model;
      lim   = (avail >= 4) ? 4'hF : ((1 << avail) - 1);
      mask  = int'($urandom_range(0, 15)) & lim;
      issue_valid = 4'(mask);
      exp_vld(cyc, lim);
      free_model = free_model - $countones(4'(mask)) + n;
      exp_fc(cyc + 1, free_model);
      step();
    end
    clear_inputs();
    step();
    step();
    rand_mode = 0;

`ifdef TAG_FREE_LIST_CHECK_EN
    // Pushing tag 3 while it is still free must set the sticky flag.
    do_reset();
    dbl_q.push_back('{cyc, 0});
    issue_valid = 4'h1;
    tag_q.push_back(0);
    step();
    clear_inputs();
    commit_valid  = 4'h1;
    commit_newest = 4'h1;
    commit_prev[0] = 7'd3;
    commit_dst[0]  = 7'd0;
    dbl_q.push_back('{cyc + 1, 1});
    dbl_q.push_back('{cyc + 3, 1});
    step();
    clear_inputs();
    for (int k = 0; k < 3; k++) step();
`endif

    step();
    step();
    check("leftover_expect", fc_q.size() + vld_q.size() + tag_q.size() + dbl_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
